// File: rtl/race_pkg.sv
// Shared types and constants for the drag-race game-flow controller.
package race_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_RACE      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  localparam int unsigned FINISH_LINE_POS_DEF = 500;
  localparam int unsigned LIGHT_W             = 3;

  // Winner code for the set of players crossing the line in the same cycle.
  function automatic winner_e first_winner(input logic hit1, input logic hit2);
    if (hit1 && hit2) return WIN_TIE;
    else if (hit1)    return WIN_P1;
    else if (hit2)    return WIN_P2;
    else              return WIN_NONE;
  endfunction

endpackage

// File: rtl/light_countdown.sv
// Start-light countdown: counts tick_1ms pulses into STEP_MS-long steps and
// advances the lit-light count, saturating at LIGHT_STEPS.
module light_countdown
  import race_pkg::*;
#(
  parameter int unsigned LIGHT_STEPS = 5,
  parameter int unsigned STEP_MS     = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               tick_i,
  output logic [LIGHT_W-1:0] light_count_o,
  output logic               step_done_c
);

  localparam int unsigned MS_W = $clog2(STEP_MS + 1);

  logic [MS_W-1:0]    ms_q;
  logic [LIGHT_W-1:0] light_q;
  logic               wrap_c;

  assign wrap_c      = (ms_q == MS_W'(STEP_MS - 1));
  assign step_done_c = en_i & tick_i & wrap_c;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      ms_q    <= '0;
      light_q <= '0;
    end else if (en_i && tick_i) begin
      if (wrap_c) begin
        ms_q <= '0;
        if (light_q != LIGHT_W'(LIGHT_STEPS)) light_q <= light_q + LIGHT_W'(1);
      end else begin
        ms_q <= ms_q + MS_W'(1);
      end
    end
  end

  assign light_count_o = light_q;

endmodule

// File: rtl/race_sequencer.sv
// Drag-race game-flow FSM: menu -> start lights -> race -> result.
// Define RACE_SEQUENCER_FALSE_START_EN to disqualify keys pressed during the countdown.
module race_sequencer
  import race_pkg::*;
#(
  parameter int unsigned FINISH_LINE_POS = FINISH_LINE_POS_DEF,
  parameter int unsigned LIGHT_STEPS     = 5,
  parameter int unsigned STEP_MS         = 1000,
  parameter int unsigned POS_W           = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1ms,
  input  logic               start_game,
  input  logic               restart,
  input  logic               p1_key,
  input  logic               p2_key,
  input  logic [POS_W-1:0]   p1_position,
  input  logic [POS_W-1:0]   p2_position,
  output logic [LIGHT_W-1:0] light_count,
  output logic               go,
  output logic               p1_enable,
  output logic               p2_enable,
  output logic               clear,
  output logic               race_done,
  output logic [1:0]         winner,
  output logic               p1_false_start,
  output logic               p2_false_start,
  output logic [2:0]         state
);

  state_e  state_q;
  winner_e winner_q;
  logic    go_q, p1_en_q, p2_en_q, clear_q, done_q;
  logic    fs1_q, fs2_q, fin1_q, fin2_q, rearm_ok_q;
  logic    key1_c, key2_c, fs1_n_c, fs2_n_c;
  logic    hit1_c, hit2_c, fin1_n_c, fin2_n_c, all_out_c;
  logic    step_done_c, last_step_c;

`ifdef RACE_SEQUENCER_FALSE_START_EN
  assign key1_c = p1_key;
  assign key2_c = p2_key;
`else
  logic unused_keys;
  assign unused_keys = p1_key ^ p2_key;
  assign key1_c      = 1'b0;
  assign key2_c      = 1'b0;
`endif

  light_countdown #(
    .LIGHT_STEPS (LIGHT_STEPS),
    .STEP_MS     (STEP_MS)
  ) u_lights (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (restart || (state_q == S_ARM)),
    .en_i          (state_q == S_COUNTDOWN),
    .tick_i        (tick_1ms),
    .light_count_o (light_count),
    .step_done_c   (step_done_c)
  );

  // A disqualified player can never register a finish.
  assign hit1_c      = (p1_position >= POS_W'(FINISH_LINE_POS)) & ~fs1_q;
  assign hit2_c      = (p2_position >= POS_W'(FINISH_LINE_POS)) & ~fs2_q;
  assign fin1_n_c    = fin1_q | hit1_c;
  assign fin2_n_c    = fin2_q | hit2_c;
  assign all_out_c   = (fin1_n_c | fs1_q) & (fin2_n_c | fs2_q);
  assign fs1_n_c     = fs1_q | key1_c;
  assign fs2_n_c     = fs2_q | key2_c;
  assign last_step_c = step_done_c & (light_count == LIGHT_W'(LIGHT_STEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      winner_q   <= WIN_NONE;
      go_q       <= 1'b0;
      p1_en_q    <= 1'b0;
      p2_en_q    <= 1'b0;
      done_q     <= 1'b0;
      fs1_q      <= 1'b0;
      fs2_q      <= 1'b0;
      fin1_q     <= 1'b0;
      fin2_q     <= 1'b0;
      clear_q    <= 1'b1;
      rearm_ok_q <= 1'b1;
    end else begin
      clear_q <= 1'b0;
      if (!start_game) rearm_ok_q <= 1'b1;
      if (restart) begin
        state_q    <= S_IDLE;
        winner_q   <= WIN_NONE;
        go_q       <= 1'b0;
        p1_en_q    <= 1'b0;
        p2_en_q    <= 1'b0;
        done_q     <= 1'b0;
        fs1_q      <= 1'b0;
        fs2_q      <= 1'b0;
        fin1_q     <= 1'b0;
        fin2_q     <= 1'b0;
        clear_q    <= 1'b1;
        rearm_ok_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_game && rearm_ok_q) begin
              state_q <= S_ARM;
              clear_q <= 1'b1;
            end
          end
          S_ARM: state_q <= S_COUNTDOWN;
          S_COUNTDOWN: begin
            fs1_q <= fs1_n_c;
            fs2_q <= fs2_n_c;
            if (last_step_c) begin
              go_q <= 1'b1;
              if (fs1_n_c && fs2_n_c) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_RACE;
                p1_en_q <= ~fs1_n_c;
                p2_en_q <= ~fs2_n_c;
              end
            end
          end
          S_RACE: begin
            fin1_q <= fin1_n_c;
            fin2_q <= fin2_n_c;
            if (winner_q == WIN_NONE) winner_q <= first_winner(hit1_c, hit2_c);
            p1_en_q <= ~fin1_n_c & ~fs1_q & ~all_out_c;
            p2_en_q <= ~fin2_n_c & ~fs2_q & ~all_out_c;
            if (all_out_c) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DONE: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign state          = state_q;
  assign winner         = winner_q;
  assign go             = go_q;
  assign p1_enable      = p1_en_q;
  assign p2_enable      = p2_en_q;
  assign clear          = clear_q;
  assign race_done      = done_q;
  assign p1_false_start = fs1_q;
  assign p2_false_start = fs2_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer (STEP_MS=4, LIGHT_STEPS=5); covers both
// builds of RACE_SEQUENCER_FALSE_START_EN.
module tb_race_sequencer;

  logic        clk = 1'b0;
  logic        reset, tick_1ms, start_game, restart, p1_key, p2_key;
  logic [31:0] p1_position, p2_position;
  logic [2:0]  light_count, state;
  logic [1:0]  winner;
  logic        go, p1_enable, p2_enable, clear, race_done;
  logic        p1_false_start, p2_false_start;

  int n_cmp = 0;
  int n_err = 0;

  race_sequencer #(
    .FINISH_LINE_POS (500),
    .LIGHT_STEPS     (5),
    .STEP_MS         (4),
    .POS_W           (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick_1ms       (tick_1ms),
    .start_game     (start_game),
    .restart        (restart),
    .p1_key         (p1_key),
    .p2_key         (p2_key),
    .p1_position    (p1_position),
    .p2_position    (p2_position),
    .light_count    (light_count),
    .go             (go),
    .p1_enable      (p1_enable),
    .p2_enable      (p2_enable),
    .clear          (clear),
    .race_done      (race_done),
    .winner         (winner),
    .p1_false_start (p1_false_start),
    .p2_false_start (p2_false_start),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    step();
  endtask

  task automatic rearm_to_countdown();
    start_game = 1'b0;
    step();
    start_game = 1'b1;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; tick_1ms = 1'b0; start_game = 1'b0; restart = 1'b0;
    p1_key = 1'b0; p2_key = 1'b0; p1_position = '0; p2_position = '0;
    step();
    step();
    check_eq("rst_clear", 32'(clear), 1);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_go", 32'(go), 0);
    check_eq("rst_light", 32'(light_count), 0);
    check_eq("rst_winner", 32'(winner), 0);
    check_eq("rst_done", 32'(race_done), 0);
    reset = 1'b0;
    check_eq("clear_first_cycle", 32'(clear), 1);
    step();
    check_eq("clear_drops", 32'(clear), 0);
    check_eq("idle_state", 32'(state), 0);

    // Start and countdown; the tick coinciding with ARM must not count
    start_game = 1'b1;
    step();
    check_eq("arm_state", 32'(state), 1);
    check_eq("arm_clear", 32'(clear), 1);
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    check_eq("cd_state", 32'(state), 2);
    check_eq("cd_clear_once", 32'(clear), 0);
    check_eq("arm_tick_ignored", 32'(light_count), 0);
    for (int i = 1; i <= 20; i++) begin
      tick_pulse();
      if (i % 4 == 0 && i < 20) check_eq("light_step", 32'(light_count), 32'(i / 4));
      if (i == 19) begin
        check_eq("no_go_at_19", 32'(go), 0);
        check_eq("light_at_19", 32'(light_count), 4);
      end
    end
    check_eq("go_at_20", 32'(go), 1);
    check_eq("light_full", 32'(light_count), 5);
    check_eq("race_state", 32'(state), 3);
    check_eq("p1_en_race", 32'(p1_enable), 1);
    check_eq("p2_en_race", 32'(p2_enable), 1);

    // p1 finishes at N, p2 at N+10
    p1_position = 32'd500;
    step();
    check_eq("win_p1", 32'(winner), 1);
    check_eq("p1_en_drop", 32'(p1_enable), 0);
    check_eq("p2_en_still", 32'(p2_enable), 1);
    check_eq("not_done_yet", 32'(race_done), 0);
    repeat (9) step();
    check_eq("race_before_p2", 32'(state), 3);
    p2_position = 32'd600;
    step();
    check_eq("done_state", 32'(state), 4);
    check_eq("race_done", 32'(race_done), 1);
    check_eq("win_held", 32'(winner), 1);
    check_eq("go_held", 32'(go), 1);
    check_eq("p2_en_done", 32'(p2_enable), 0);

    // Restart from DONE; start_game still high must not re-arm
    p1_position = '0; p2_position = '0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_eq("rs_state", 32'(state), 0);
    check_eq("rs_clear", 32'(clear), 1);
    check_eq("rs_winner", 32'(winner), 0);
    check_eq("rs_light", 32'(light_count), 0);
    check_eq("rs_go", 32'(go), 0);
    check_eq("rs_done", 32'(race_done), 0);
    step();
    check_eq("no_rearm", 32'(state), 0);
    check_eq("rs_clear_once", 32'(clear), 0);
    start_game = 1'b0;
    step();
    start_game = 1'b1;
    step();
    check_eq("rearm", 32'(state), 1);
    step();
    repeat (12) tick_pulse();
    check_eq("cd_light3", 32'(light_count), 3);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_eq("abort_state", 32'(state), 0);
    check_eq("abort_light", 32'(light_count), 0);
    check_eq("abort_clear", 32'(clear), 1);
    step();
    check_eq("abort_clear_once", 32'(clear), 0);

    // Countdown stalls without ticks; p2 presses key early
    rearm_to_countdown();
    check_eq("cd2_state", 32'(state), 2);
    p2_key = 1'b1;
    repeat (5) tick_pulse();
    p2_key = 1'b0;
    check_eq("stall_light_pre", 32'(light_count), 1);
    repeat (10000) step();
    check_eq("stall_light", 32'(light_count), 1);
    check_eq("stall_no_go", 32'(go), 0);
    check_eq("stall_state", 32'(state), 2);
    repeat (15) tick_pulse();
    check_eq("go2", 32'(go), 1);
    check_eq("race2_state", 32'(state), 3);
`ifdef RACE_SEQUENCER_FALSE_START_EN
    check_eq("p2_fs", 32'(p2_false_start), 1);
    check_eq("p1_fs", 32'(p1_false_start), 0);
    check_eq("p2_en_dq", 32'(p2_enable), 0);
    check_eq("p1_en_ok", 32'(p1_enable), 1);
    p1_position = 32'd499;
    step();
    check_eq("fs_no_win_499", 32'(winner), 0);
    check_eq("fs_race_499", 32'(state), 3);
    p1_position = 32'd500;
    step();
    check_eq("fs_win_p1", 32'(winner), 1);
    check_eq("fs_done", 32'(state), 4);
    check_eq("fs_race_done", 32'(race_done), 1);
`else
    check_eq("p2_fs_tied", 32'(p2_false_start), 0);
    check_eq("p1_fs_tied", 32'(p1_false_start), 0);
    check_eq("p2_en_keys_ignored", 32'(p2_enable), 1);
    p1_position = 32'd499;
    step();
    check_eq("no_win_499", 32'(winner), 0);
    check_eq("race_499", 32'(state), 3);
`endif

    // Simultaneous finish gives a tie
    p1_position = '0; p2_position = '0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    rearm_to_countdown();
    repeat (20) tick_pulse();
    check_eq("race3_state", 32'(state), 3);
    p1_position = 32'd500;
    p2_position = 32'd500;
    step();
    check_eq("tie_winner", 32'(winner), 3);
    check_eq("tie_done", 32'(race_done), 1);
    check_eq("tie_state", 32'(state), 4);
    check_eq("tie_p1_en", 32'(p1_enable), 0);
    check_eq("tie_p2_en", 32'(p2_enable), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
Central game-flow controller for the two-player drag race, running on the 65 MHz pixel clock.
- Replaces the scattered status glue (light-timer compare, finish compares, enable/restart gating) with one FSM.
- Sequences menu start → start-light countdown → race → result, and clears timers/controllers for the next run.
- Drives the player controller enables, player timer enables, the light count consumed by start-light drawing, and the winner consumed by the scoreboard.

Parameters:
- FINISH_LINE_POS, 500, position at or above which a player has finished.
- LIGHT_STEPS, 5, number of countdown light steps before GO.
- STEP_MS, 1000, tick_1ms pulses per light step.
- POS_W, 32, width of player position inputs.

Ports:
- clk  in  1  65 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- tick_1ms  in  1  one-clk-wide pulse every 1 ms.
- start_game  in  1  level from game menu; high = game selected.
- restart  in  1  one-clk pulse from scoreboard (back to menu).
- p1_key  in  1  player 1 throttle key level.
- p2_key  in  1  player 2 throttle key level.
- p1_position  in  POS_W  player 1 distance.
- p2_position  in  POS_W  player 2 distance.
- light_count  out  3  lit start lights, 0..LIGHT_STEPS.
- go  out  1  high while racing (lights complete).
- p1_enable  out  1  enables p1 controller and p1 timer.
- p2_enable  out  1  enables p2 controller and p2 timer.
- clear  out  1  one-clk pulse resetting timers/controllers.
- race_done  out  1  both players finished or race decided.
- winner  out  2  00 none, 01 p1, 10 p2, 11 tie.
- p1_false_start  out  1  p1 disqualified (feature-dependent).
- p2_false_start  out  1  p2 disqualified (feature-dependent).
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (sync, active-high) → state IDLE.
  - All outputs 0 except `clear`, which is 1 during reset and for the first cycle after it.
  - Internal step/ms counters cleared.
- IDLE:
  - Outputs 0.
  - On `start_game` = 1 → ARM. Level-sensitive, but re-entry requires `start_game` to be seen low first after `restart`.
- ARM: single cycle. `clear` = 1. ms counter = 0, `light_count` = 0. → COUNTDOWN.
- COUNTDOWN:
  - Each `tick_1ms` increments the ms counter.
  - When the counter reaches STEP_MS−1 on a tick: counter wraps to 0 and `light_count` increments.
  - When `light_count` would reach LIGHT_STEPS: `light_count` is set to LIGHT_STEPS, `go` = 1 registered, → RACE.
  - Latency: LIGHT_STEPS·STEP_MS ticks from ARM to `go`.
- RACE:
  - `pN_enable` = `go` & ~finishedN & ~false_startN.
  - finishedN is a sticky flag set when `pN_position` ≥ FINISH_LINE_POS; compare is unsigned.
  - The first flag set latches `winner`. Both set in the same cycle → `winner` = 11. Later finishes do not change `winner`.
  - When both players are finished or disqualified → DONE.
- DONE:
  - `race_done` = 1; enables 0; `go` held; `winner` held.
- `restart` pulse in any non-IDLE state:
  - → IDLE next cycle, with `clear` = 1 for one cycle.
  - `winner`, false-start flags and `light_count` cleared.
  - `restart` in IDLE: only `clear` pulses.
- Simultaneous events:
  - `restart` beats every transition.
  - `tick_1ms` coinciding with ARM is ignored.
  - `start_game` falling mid-race is ignored; only `restart` aborts.
- Enables are registered: 1-clk latency from the position compare to the enable drop.

Optional Feature:
- Macro: RACE_SEQUENCER_FALSE_START_EN.
- With the macro:
  - `pN_key` high on any COUNTDOWN cycle sets sticky `pN_false_start`.
  - That player's enable stays 0 in RACE.
  - The other player wins (`winner` = 01/10) when they finish.
  - Both players false-start → `winner` = 00, → DONE on the GO cycle.
- Without the macro:
  - Keys are ignored; `pN_false_start` is tied to 0.
  - The p1_key/p2_key ports remain present but unused.

Decomposition:
- Package race_pkg:
  - state encoding (IDLE=0, ARM=1, COUNTDOWN=2, RACE=3, DONE=4);
  - winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_TIE);
  - default FINISH_LINE_POS.
- One sub-module, light_countdown:
  - ms/step counter with load/clear;
  - outputs `light_count` and a `step_done` pulse;
  - parameterised by LIGHT_STEPS and STEP_MS.

Test Plan:
1. Reset, then `start_game` = 1 with STEP_MS=4, LIGHT_STEPS=5 → `clear` pulses once; `light_count` steps 0..5 every 4 ticks; `go` rises exactly 20 ticks after ARM.
2. In RACE, p1_position=500 at cycle N, p2_position=600 at N+10 → `winner`=01 from N+1; p1_enable=0 from N+1; DONE and `race_done`=1 at N+11.
3. p1_position=500 and p2_position=500 in the same cycle → `winner`=11, `race_done`=1.
4. `restart` pulse during COUNTDOWN (`light_count`=3) → IDLE next cycle; `light_count`=0; `clear`=1 for one cycle; no re-arm until `start_game` toggles low→high.
5. With RACE_SEQUENCER_FALSE_START_EN, p2_key=1 during COUNTDOWN → `p2_false_start`=1; p2_enable stays 0; p1 reaches 499 → no winner, reaches 500 → `winner`=01, DONE.
6. `tick_1ms` held 0 in COUNTDOWN for 10,000 clk → `light_count` stays constant, no `go`.
